timer_countdown_bcd: RTL and testbench
======================================

// Module: timer_countdown_bcd
// PURPOSE
//  Microwave cook-time countdown: user-entered BCD MM:SS value, counted down one second per
//  prescaled tick. Stops and holds at 00:00; never wraps. Sits after the timer-input counters,
//  drives display digits and the magnetron enable (running) / buzzer request (done).
// PARAMETERS
//  CLK_PER_SEC   10   clk cycles per one-second decrement (>=2; board build overrides)
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst        in   1  synchronous, active-high reset
//  load       in   1  capture d_* digits as new count
//  d_min_t    in   4  minutes tens BCD
//  d_min_o    in   4  minutes ones BCD
//  d_sec_t    in   4  seconds tens BCD
//  d_sec_o    in   4  seconds ones BCD
//  start      in   1  begin / resume countdown
//  pause      in   1  suspend countdown (door open / stop key)
//  clear      in   1  abort, zero count
//  q_min_t    out  4  current minutes tens
//  q_min_o    out  4  current minutes ones
//  q_sec_t    out  4  current seconds tens
//  q_sec_o    out  4  current seconds ones
//  running    out  1  1 while state RUNNING
//  done       out  1  level, 1 while state DONE
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high (rst sampled on rising clk).
//  - Reset: all q_* = 0, running = 0, done = 0, prescaler = 0, state IDLE.
//  - States: IDLE, PAUSED, RUNNING, DONE. Outputs registered; running/done decoded from state.
//  - Priority per cycle: rst > clear > load > pause > start.
//  - clear (any state): q_* = 0, prescaler = 0, -> IDLE next cycle.
//  - load (IDLE/PAUSED/DONE only; ignored in RUNNING): q_* <= d_* next cycle, prescaler = 0,
//    -> IDLE. Clamp: any ones digit >9 -> 9; d_sec_t >5 -> 5; d_min_t >9 -> 9. Max 99:59.
//  - start in IDLE/PAUSED: if count != 00:00 -> RUNNING next cycle; if 00:00 ignored.
//    start in RUNNING/DONE: no effect.
//  - RUNNING: prescaler increments each cycle 0..CLK_PER_SEC-1. On cycle where it equals
//    CLK_PER_SEC-1: prescaler <= 0, count decrements by 1 s (BCD borrow chain:
//    sec_o 0->9 borrow sec_t; sec_t 0->5 borrow min_o; min_o 0->9 borrow min_t).
//    First decrement is visible CLK_PER_SEC cycles after running first reads 1.
//  - Decrement producing 00:00 -> DONE in the same edge: running = 0, done = 1.
//  - Non-recycling: count never decrements below 00:00; no 99:59 wrap. DONE holds until
//    clear, load or rst.
//  - pause in RUNNING -> PAUSED next cycle; prescaler and q_* hold (partial second kept).
//    pause and start both high in RUNNING: pause wins.
//  - start in PAUSED resumes from held prescaler value.
//  - pause in IDLE/PAUSED/DONE: no effect.
//  - rst mid-count: next edge all zero, IDLE, no decrement that cycle.
// TESTING
//  1 rst=1 2 clk, release -> q=00:00, running=0, done=0; start alone -> stays IDLE.
//  2 load 00:12, start -> running=1; after 10 clk 00:11; after 120 clk 00:00, done=1, running=0;
//    20 more clk -> still 00:00, done=1.
//  3 load 01:00, start, 10 clk -> 00:59; load 10:00 run 10 clk -> 09:59 (full borrow chain).
//  4 load 00:05, start, 4 clk, pause 1 clk, wait 30 clk -> 00:05 held; start -> 00:04 exactly
//    6 clk after running rises again.
//  5 load d_sec_o=12, d_sec_t=7 -> q_sec=59; load while RUNNING -> ignored; pause+start
//    together while RUNNING -> PAUSED.
//  6 RUNNING at 00:03, assert clear -> 00:00 IDLE; repeat with rst -> same, done=0.

Source files
------------

// File: rtl/timer_countdown_bcd.sv
// Microwave cook-time countdown on a BCD MM:SS value, one decrement per prescaled second.
// Stops at 00:00 (never wraps); running/done are decoded from the registered state.
module timer_countdown_bcd #(
   parameter int unsigned CLK_PER_SEC = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] d_min_t,
   input  logic [3:0] d_min_o,
   input  logic [3:0] d_sec_t,
   input  logic [3:0] d_sec_o,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   output logic [3:0] q_min_t,
   output logic [3:0] q_min_o,
   output logic [3:0] q_sec_t,
   output logic [3:0] q_sec_o,
   output logic       running,
   output logic       done
);

   localparam int unsigned PresW = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
   localparam logic [PresW-1:0] PresMax = PresW'(CLK_PER_SEC - 1);

   typedef enum logic [1:0] {StIdle, StPaused, StRunning, StDone} state_e;

   state_e           state_q, state_d;
   logic [PresW-1:0] pres_q, pres_d;
   logic [3:0]       min_t_q, min_t_d, min_o_q, min_o_d;
   logic [3:0]       sec_t_q, sec_t_d, sec_o_q, sec_o_d;

   logic [3:0] dec_min_t, dec_min_o, dec_sec_t, dec_sec_o;
   logic       count_zero, dec_zero;

   function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] lim);
      return (v > lim) ? lim : v;
   endfunction

   assign count_zero = (min_t_q == 4'd0) && (min_o_q == 4'd0) &&
                       (sec_t_q == 4'd0) && (sec_o_q == 4'd0);

   // One-second BCD borrow chain; only used while the count is non-zero.
   always_comb begin
      dec_min_t = min_t_q;
      dec_min_o = min_o_q;
      dec_sec_t = sec_t_q;
      dec_sec_o = sec_o_q;
      if (sec_o_q != 4'd0) begin
         dec_sec_o = sec_o_q - 4'd1;
      end else begin
         dec_sec_o = 4'd9;
         if (sec_t_q != 4'd0) begin
            dec_sec_t = sec_t_q - 4'd1;
         end else begin
            dec_sec_t = 4'd5;
            if (min_o_q != 4'd0) begin
               dec_min_o = min_o_q - 4'd1;
            end else begin
               dec_min_o = 4'd9;
               dec_min_t = min_t_q - 4'd1;
            end
         end
      end
   end

   assign dec_zero = (dec_min_t == 4'd0) && (dec_min_o == 4'd0) &&
                     (dec_sec_t == 4'd0) && (dec_sec_o == 4'd0);

   always_comb begin
      state_d = state_q;
      pres_d  = pres_q;
      min_t_d = min_t_q;
      min_o_d = min_o_q;
      sec_t_d = sec_t_q;
      sec_o_d = sec_o_q;
      if (clear) begin
         state_d = StIdle;
         pres_d  = '0;
         min_t_d = 4'd0;
         min_o_d = 4'd0;
         sec_t_d = 4'd0;
         sec_o_d = 4'd0;
      end else if (load && (state_q != StRunning)) begin
         state_d = StIdle;
         pres_d  = '0;
         min_t_d = clamp(d_min_t, 4'd9);
         min_o_d = clamp(d_min_o, 4'd9);
         sec_t_d = clamp(d_sec_t, 4'd5);
         sec_o_d = clamp(d_sec_o, 4'd9);
      end else begin
         unique case (state_q)
            StIdle, StPaused: begin
               if (!pause && start && !count_zero) begin
                  state_d = StRunning;
               end
            end
            StRunning: begin
               if (pause) begin
                  state_d = StPaused;
               end else if (pres_q == PresMax) begin
                  pres_d = '0;
                  if (!count_zero) begin
                     min_t_d = dec_min_t;
                     min_o_d = dec_min_o;
                     sec_t_d = dec_sec_t;
                     sec_o_d = dec_sec_o;
                  end
                  if (count_zero || dec_zero) begin
                     state_d = StDone;
                  end
               end else begin
                  pres_d = pres_q + 1'b1;
               end
            end
            StDone: begin
               state_d = StDone;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         pres_q  <= '0;
         min_t_q <= 4'd0;
         min_o_q <= 4'd0;
         sec_t_q <= 4'd0;
         sec_o_q <= 4'd0;
      end else begin
         state_q <= state_d;
         pres_q  <= pres_d;
         min_t_q <= min_t_d;
         min_o_q <= min_o_d;
         sec_t_q <= sec_t_d;
         sec_o_q <= sec_o_d;
      end
   end

   assign q_min_t = min_t_q;
   assign q_min_o = min_o_q;
   assign q_sec_t = sec_t_q;
   assign q_sec_o = sec_o_q;
   assign running = (state_q == StRunning);
   assign done    = (state_q == StDone);

endmodule

// File: tb/tb_timer_countdown_bcd.sv
// Directed-vector bench for timer_countdown_bcd; count is checked as a packed 16-bit BCD MMSS.
module tb_timer_countdown_bcd;

   logic       clk = 1'b0;
   logic       rst, load, start, pause, clear;
   logic [3:0] d_min_t, d_min_o, d_sec_t, d_sec_o;
   logic [3:0] q_min_t, q_min_o, q_sec_t, q_sec_o;
   logic       running, done;

   int vec_cnt = 0;
   int err_cnt = 0;

   timer_countdown_bcd #(.CLK_PER_SEC(10)) dut (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .d_min_t (d_min_t),
      .d_min_o (d_min_o),
      .d_sec_t (d_sec_t),
      .d_sec_o (d_sec_o),
      .start   (start),
      .pause   (pause),
      .clear   (clear),
      .q_min_t (q_min_t),
      .q_min_o (q_min_o),
      .q_sec_t (q_sec_t),
      .q_sec_o (q_sec_o),
      .running (running),
      .done    (done)
   );

   always #5 clk = ~clk;

   wire [15:0] count = {q_min_t, q_min_o, q_sec_t, q_sec_o};

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Advance n rising edges; outputs are sampled 1 time unit after the last edge.
   task automatic cycle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_load(input logic [3:0] mt, mo, st, so);
      d_min_t = mt;
      d_min_o = mo;
      d_sec_t = st;
      d_sec_o = so;
      load = 1'b1;
      cycle(1);
      load = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cycle(1);
      start = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      cycle(1);
      clear = 1'b0;
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
      d_min_t = 4'd0; d_min_o = 4'd0; d_sec_t = 4'd0; d_sec_o = 4'd0;

      // 1: reset state, start at 00:00 ignored
      cycle(2);
      rst = 1'b0;
      check_eq("rst_count", count, 16'h0000);
      check_eq("rst_running", 16'(running), 16'd0);
      check_eq("rst_done", 16'(done), 16'd0);
      pulse_start();
      check_eq("start_zero_ignored", 16'(running), 16'd0);

      // 2: 00:12 countdown to DONE, holds
      do_load(4'd0, 4'd0, 4'd1, 4'd2);
      check_eq("load_0012", count, 16'h0012);
      pulse_start();
      check_eq("run_0012", 16'(running), 16'd1);
      cycle(9);
      check_eq("no_dec_at_9", count, 16'h0012);
      cycle(1);
      check_eq("first_dec", count, 16'h0011);
      cycle(109);
      check_eq("at_0001", count, 16'h0001);
      check_eq("still_running", 16'(running), 16'd1);
      cycle(1);
      check_eq("reach_0000", count, 16'h0000);
      check_eq("done_set", 16'(done), 16'd1);
      check_eq("running_clr", 16'(running), 16'd0);
      cycle(20);
      check_eq("hold_0000", count, 16'h0000);
      check_eq("hold_done", 16'(done), 16'd1);
      pulse_start();
      check_eq("start_in_done", 16'(done), 16'd1);

      // 3: borrow chains
      do_load(4'd0, 4'd1, 4'd0, 4'd0);
      check_eq("load_clears_done", 16'(done), 16'd0);
      pulse_start();
      cycle(10);
      check_eq("borrow_0100", count, 16'h0059);
      pause = 1'b1;
      cycle(1);
      pause = 1'b0;
      do_load(4'd1, 4'd0, 4'd0, 4'd0);
      pulse_start();
      cycle(10);
      check_eq("borrow_1000", count, 16'h0959);

      // 4: pause keeps the partial second
      pulse_clear();
      do_load(4'd0, 4'd0, 4'd0, 4'd5);
      pulse_start();
      cycle(4);
      pause = 1'b1;
      cycle(1);
      pause = 1'b0;
      check_eq("paused", 16'(running), 16'd0);
      cycle(30);
      check_eq("pause_hold", count, 16'h0005);
      pulse_start();
      check_eq("resumed", 16'(running), 16'd1);
      cycle(5);
      check_eq("resume_5clk", count, 16'h0005);
      cycle(1);
      check_eq("resume_6clk", count, 16'h0004);

      // 5: clamping, load ignored while running, pause beats start
      pulse_clear();
      do_load(4'd0, 4'd0, 4'd7, 4'd12);
      check_eq("clamp_sec", count, 16'h0059);
      do_load(4'd15, 4'd11, 4'd9, 4'd10);
      check_eq("clamp_all", count, 16'h9959);
      pulse_start();
      do_load(4'd0, 4'd1, 4'd2, 4'd3);
      check_eq("load_in_run", count, 16'h9959);
      check_eq("load_in_run_st", 16'(running), 16'd1);
      pause = 1'b1;
      start = 1'b1;
      cycle(1);
      pause = 1'b0;
      start = 1'b0;
      check_eq("pause_wins", 16'(running), 16'd0);
      cycle(15);
      check_eq("pause_wins_hold", count, 16'h9959);

      // 6: clear and rst mid-count
      pulse_clear();
      do_load(4'd0, 4'd0, 4'd0, 4'd3);
      pulse_start();
      cycle(3);
      check_eq("pre_clear", count, 16'h0003);
      pulse_clear();
      check_eq("clear_count", count, 16'h0000);
      check_eq("clear_running", 16'(running), 16'd0);
      check_eq("clear_done", 16'(done), 16'd0);
      do_load(4'd0, 4'd0, 4'd0, 4'd3);
      pulse_start();
      cycle(9);
      rst = 1'b1;
      cycle(1);
      rst = 1'b0;
      check_eq("rst_mid_count", count, 16'h0000);
      check_eq("rst_mid_running", 16'(running), 16'd0);
      cycle(10);
      check_eq("rst_stays_idle", count, 16'h0000);
      do_load(4'd0, 4'd0, 4'd0, 4'd1);
      pulse_start();
      cycle(10);
      check_eq("done_before_rst", 16'(done), 16'd1);
      rst = 1'b1;
      cycle(1);
      rst = 1'b0;
      check_eq("rst_done_clr", 16'(done), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
